// File: rtl/sort_seq.sv
// Sequencer for the SORT phase: bubble-sorts points 1..N_PTS-1 angularly about point 0
// by requesting cross products and issuing swaps to the point register file.
//
// state  | meaning
// IDLE   | waiting for en; counters loaded on the way out
// REQ    | cmp_req high for pair (j, j+1) until cmp_ack
// SWAP   | one-cycle swap pulse for the current pair
// DONE   | one-cycle sort_done pulse
// HOLD   | waiting for en to drop so only one done is issued per command
module sort_seq #(
    parameter int N_PTS  = 6,
    parameter int IDX_W  = 3,
    parameter int CROS_W = 23,
    parameter int SWP_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    output logic              cmp_req,
    output logic [IDX_W-1:0]  idx_a,
    output logic [IDX_W-1:0]  idx_b,
    input  logic              cmp_ack,
    input  logic [CROS_W-1:0] cross_res,
    output logic              swap,
    output logic              sort_done,
    output logic [SWP_W-1:0]  swap_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_SWAP,
        S_DONE,
        S_HOLD
    } state_t;

    localparam logic [IDX_W-1:0] C_ONE       = IDX_W'(1);
    localparam logic [IDX_W-1:0] C_TWO       = IDX_W'(2);
    localparam logic [IDX_W-1:0] C_TOP_J     = IDX_W'(N_PTS - 2);
    localparam logic [IDX_W-1:0] C_LAST_PASS = IDX_W'(N_PTS - 3);

    state_t           r_state, w_state_nxt;
    logic [IDX_W-1:0] r_pass, w_pass_nxt;
    logic [IDX_W-1:0] r_j, w_j_nxt;
    logic [IDX_W-1:0] r_idx_b;
    logic             r_swapped, w_swapped_nxt;
    logic [SWP_W-1:0] r_swap_cnt, w_swap_cnt_nxt;
    logic [IDX_W-1:0] w_last_j;
    logic             w_neg;
    logic             w_adv;
    logic             w_swapped_now;

    assign w_last_j = C_TOP_J - r_pass;
    assign w_neg    = $signed(cross_res) < $signed({CROS_W{1'b0}});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_pass     <= '0;
            r_j        <= C_ONE;
            r_idx_b    <= C_TWO;
            r_swapped  <= 1'b0;
            r_swap_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_pass     <= w_pass_nxt;
            r_j        <= w_j_nxt;
            r_idx_b    <= w_j_nxt + C_ONE;
            r_swapped  <= w_swapped_nxt;
            r_swap_cnt <= w_swap_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_pass_nxt     = r_pass;
        w_j_nxt        = r_j;
        w_swapped_nxt  = r_swapped;
        w_swap_cnt_nxt = r_swap_cnt;
        w_adv          = 1'b0;
        w_swapped_now  = r_swapped;

        case (r_state)
            S_IDLE: begin
                if (en) begin
                    w_state_nxt    = S_REQ;
                    w_pass_nxt     = '0;
                    w_j_nxt        = C_ONE;
                    w_swapped_nxt  = 1'b0;
                    w_swap_cnt_nxt = '0;
                end
            end
            S_REQ: begin
                if (!en) begin
                    w_state_nxt = S_IDLE;
                end else if (cmp_ack) begin
                    if (w_neg) begin
                        w_state_nxt = S_SWAP;
                    end else begin
                        w_adv = 1'b1;
                    end
                end
            end
            S_SWAP: begin
                // The datapath exchanges on this edge regardless of abort, so it is counted.
                w_swapped_nxt = 1'b1;
                w_swapped_now = 1'b1;
                if (r_swap_cnt != {SWP_W{1'b1}}) begin
                    w_swap_cnt_nxt = r_swap_cnt + 1'b1;
                end
                if (!en) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_adv = 1'b1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (!en) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_adv) begin
            if (r_j < w_last_j) begin
                w_j_nxt     = r_j + C_ONE;
                w_state_nxt = S_REQ;
            end else if ((r_pass == C_LAST_PASS) || !w_swapped_now) begin
                w_state_nxt = S_DONE;
            end else begin
                w_pass_nxt    = r_pass + C_ONE;
                w_j_nxt       = C_ONE;
                w_swapped_nxt = 1'b0;
                w_state_nxt   = S_REQ;
            end
        end
    end

    assign cmp_req   = (r_state == S_REQ);
    assign swap      = (r_state == S_SWAP);
    assign sort_done = (r_state == S_DONE);
    assign idx_a     = r_j;
    assign idx_b     = r_idx_b;
    assign swap_cnt  = r_swap_cnt;

endmodule

// File: tb/tb_sort_seq.sv
// Scoreboard bench for sort_seq: a bubble-sort reference model queues the expected
// compare/swap/done events and a negedge monitor checks what the DUT presents.
module tb_sort_seq;

    localparam int N_PTS  = 6;
    localparam int IDX_W  = 3;
    localparam int CROS_W = 23;
    localparam int SWP_W  = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              en = 1'b0;
    logic              cmp_req;
    logic [IDX_W-1:0]  idx_a;
    logic [IDX_W-1:0]  idx_b;
    logic              cmp_ack;
    logic [CROS_W-1:0] cross_res;
    logic              swap;
    logic              sort_done;
    logic [SWP_W-1:0]  swap_cnt;

    sort_seq #(
        .N_PTS (N_PTS),
        .IDX_W (IDX_W),
        .CROS_W(CROS_W),
        .SWP_W (SWP_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .cmp_req  (cmp_req),
        .idx_a    (idx_a),
        .idx_b    (idx_b),
        .cmp_ack  (cmp_ack),
        .cross_res(cross_res),
        .swap     (swap),
        .sort_done(sort_done),
        .swap_cnt (swap_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int typ;   // 0 compare accepted, 1 swap pulse, 2 done pulse
        int a;
        int b;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    int  mode = 0;          // 0: constant cross_res, 1: keys held in dp[]
    int  cval = 0;
    int  ack_dly = 0;
    int  dp[8];
    int  init_keys[8];
    bit  load_pend = 1'b0;
    int  wait_cnt = 0;
    int  cyc = 0;
    int  done_cnt = 0;
    int  req_seen = 0;
    int  swp_seen = 0;
    int  first_req_cyc = -1;
    int  done_cyc = -1;
    bit  chk_stable = 1'b0;
    bit  prev_wait = 1'b0;
    int  prev_a = 0;
    int  prev_b = 0;

    // Behavioural cross unit: responds after ack_dly cycles of cmp_req.
    always_comb begin
        cmp_ack = cmp_req && (wait_cnt >= ack_dly);
        if (mode == 0) cross_res = CROS_W'(cval);
        else           cross_res = CROS_W'(dp[idx_b] - dp[idx_a]);
    end

    always @(posedge clk) begin
        wait_cnt <= (cmp_req && !cmp_ack) ? wait_cnt + 1 : 0;
        cyc      <= cyc + 1;
        if (load_pend) begin
            for (int i = 0; i < 8; i++) dp[i] <= init_keys[i];
        end else if (swap) begin
            dp[idx_a] <= dp[idx_b];
            dp[idx_b] <= dp[idx_a];
        end
    end

    task automatic chk_eq(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d", name, act, req);
        end
    endtask

    task automatic expect_ev(input int typ, input int a, input int b);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL event_unexpected: got type %0d pair (%0d,%0d), required none", typ, a, b);
        end else begin
            e = exp_q.pop_front();
            if (e.typ != typ || (typ != 2 && (e.a != a || e.b != b)) || (typ != 0 && cmp_req)) begin
                errors++;
                $display("FAIL event: got type %0d pair (%0d,%0d) req %0d, required type %0d pair (%0d,%0d) req 0",
                         typ, a, b, cmp_req, e.typ, e.a, e.b);
            end
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (chk_stable && prev_wait) begin
                chk_eq("stable_req", cmp_req, 1);
                chk_eq("stable_idx_a", idx_a, prev_a);
                chk_eq("stable_idx_b", idx_b, prev_b);
            end
            prev_wait = cmp_req && !cmp_ack;
            prev_a    = idx_a;
            prev_b    = idx_b;
            if (cmp_req && first_req_cyc < 0) first_req_cyc = cyc;
            if (cmp_req && cmp_ack) begin
                req_seen++;
                expect_ev(0, idx_a, idx_b);
            end
            if (swap) begin
                swp_seen++;
                expect_ev(1, idx_a, idx_b);
            end
            if (sort_done) begin
                done_cyc = cyc;
                expect_ev(2, 0, 0);
                done_cnt++;
            end
        end else begin
            prev_wait = 1'b0;
        end
    end

    // Plain bubble sort with early exit over points 1..N_PTS-1.
    task automatic model_sort(input int md, input int cv, output int nreq, output int nsw);
        int  k[8];
        int  t;
        bit  sw;
        bit  neg;
        ev_t e;
        nreq = 0;
        nsw  = 0;
        for (int i = 0; i < 8; i++) k[i] = init_keys[i];
        for (int p = 0; p <= N_PTS - 3; p++) begin
            sw = 1'b0;
            for (int j = 1; j <= N_PTS - 2 - p; j++) begin
                neg = (md == 0) ? (cv < 0) : (k[j] > k[j+1]);
                e.typ = 0; e.a = j; e.b = j + 1;
                exp_q.push_back(e);
                nreq++;
                if (neg) begin
                    e.typ = 1;
                    exp_q.push_back(e);
                    t = k[j]; k[j] = k[j+1]; k[j+1] = t;
                    sw = 1'b1;
                    nsw++;
                end
            end
            if (!sw) break;
        end
        e.typ = 2; e.a = 0; e.b = 0;
        exp_q.push_back(e);
    endtask

    task automatic load_keys(input int k0, input int k1, input int k2, input int k3, input int k4, input int k5);
        init_keys[0] = k0; init_keys[1] = k1; init_keys[2] = k2;
        init_keys[3] = k3; init_keys[4] = k4; init_keys[5] = k5;
        init_keys[6] = 0;  init_keys[7] = 0;
        load_pend = 1'b1;
        @(posedge clk);
        #1 load_pend = 1'b0;
    endtask

    task automatic run_sort(input string tag, input int md, input int cv, input int dly, output int lat);
        int nreq, nsw, base, n, sat;
        mode = md; cval = cv; ack_dly = dly;
        model_sort(md, cv, nreq, nsw);
        base = done_cnt;
        first_req_cyc = -1;
        req_seen = 0;
        swp_seen = 0;
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        chk_eq({tag, "_first_req"}, cmp_req, 1);
        chk_eq({tag, "_first_idx_a"}, idx_a, 1);
        chk_eq({tag, "_start_swap_cnt"}, swap_cnt, 0);
        n = 0;
        while (done_cnt == base && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk_eq({tag, "_done_seen"}, done_cnt - base, 1);
        chk_eq({tag, "_queue_left"}, exp_q.size(), 0);
        chk_eq({tag, "_req_count"}, req_seen, nreq);
        chk_eq({tag, "_swap_pulses"}, swp_seen, nsw);
        sat = (nsw > 15) ? 15 : nsw;
        chk_eq({tag, "_swap_cnt"}, swap_cnt, sat);
        lat = done_cyc - first_req_cyc;
        repeat (3) @(negedge clk);
        chk_eq({tag, "_hold_single_done"}, done_cnt - base, 1);
        en = 1'b0;
        repeat (2) @(negedge clk);
        chk_eq({tag, "_idle_req"}, cmp_req, 0);
        exp_q.delete();
    endtask

    initial begin
        int lat, n, base, nreq, nsw;
        ev_t e;

        repeat (3) @(negedge clk);
        chk_eq("rst_cmp_req", cmp_req, 0);
        chk_eq("rst_swap", swap, 0);
        chk_eq("rst_done", sort_done, 0);
        chk_eq("rst_idx_a", idx_a, 1);
        chk_eq("rst_idx_b", idx_b, 2);
        chk_eq("rst_swap_cnt", swap_cnt, 0);
        reset = 1'b1;

        load_keys(0, 0, 0, 0, 0, 0);
        run_sort("sorted", 0, 5, 0, lat);
        chk_eq("sorted_latency", lat, 4);
        chk_eq("sorted_final_swap_cnt", swap_cnt, 0);

        run_sort("reverse", 0, -1, 0, lat);
        chk_eq("reverse_swap_cnt_10", swap_cnt, 10);
        chk_eq("reverse_req_10", req_seen, 10);

        load_keys(0, 1, 3, 2, 4, 5);
        run_sort("one_swap", 1, 0, 1, lat);
        chk_eq("one_swap_req_7", req_seen, 7);
        chk_eq("one_swap_cnt_1", swap_cnt, 1);

        chk_stable = 1'b1;
        run_sort("delayed", 0, 0, 3, lat);
        chk_stable = 1'b0;
        chk_eq("delayed_swap_cnt", swap_cnt, 0);

        // Abort while waiting on the second compare.
        load_keys(0, 5, 1, 2, 3, 4);
        mode = 1; ack_dly = 4;
        e.typ = 0; e.a = 1; e.b = 2; exp_q.push_back(e);
        e.typ = 1; exp_q.push_back(e);
        base = done_cnt;
        @(negedge clk);
        en = 1'b1;
        n = 0;
        while (!(cmp_req && idx_a == 2) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk_eq("abort_reached_2nd_req", (cmp_req && idx_a == 2) ? 1 : 0, 1);
        en = 1'b0;
        @(negedge clk);
        chk_eq("abort_req_low", cmp_req, 0);
        repeat (5) @(negedge clk);
        chk_eq("abort_no_done", done_cnt - base, 0);
        chk_eq("abort_queue_left", exp_q.size(), 0);
        chk_eq("abort_swap_cnt_kept", swap_cnt, 1);
        exp_q.delete();
        load_keys(0, 2, 1, 4, 3, 5);
        run_sort("restart", 1, 0, 0, lat);

        for (int r = 0; r < 8; r++) begin
            load_keys(0, $urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9),
                      $urandom_range(0, 9), $urandom_range(0, 9));
            run_sort($sformatf("rand%0d", r), 1, 0, $urandom_range(0, 2), lat);
        end

        // Reset asserted during the second swap pulse.
        mode = 0; cval = -1; ack_dly = 0;
        model_sort(0, -1, nreq, nsw);
        swp_seen = 0;
        @(negedge clk);
        en = 1'b1;
        n = 0;
        while (!(swap && swp_seen >= 1) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk_eq("rst_mid_swap_reached", swap, 1);
        reset = 1'b0;
        #1;
        chk_eq("rst_mid_swap", swap, 0);
        chk_eq("rst_mid_cmp_req", cmp_req, 0);
        chk_eq("rst_mid_done", sort_done, 0);
        chk_eq("rst_mid_idx_a", idx_a, 1);
        chk_eq("rst_mid_swap_cnt", swap_cnt, 0);
        exp_q.delete();
        model_sort(0, -1, nreq, nsw);
        base = done_cnt;
        swp_seen = 0;
        @(negedge clk);
        reset = 1'b1;
        n = 0;
        while (done_cnt == base && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk_eq("post_rst_done", done_cnt - base, 1);
        chk_eq("post_rst_swap_cnt", swap_cnt, 10);
        repeat (20) @(negedge clk);
        chk_eq("hold_no_second_done", done_cnt - base, 1);
        chk_eq("hold_req_low", cmp_req, 0);
        chk_eq("post_rst_queue_left", exp_q.size(), 0);
        en = 1'b0;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
